// File: rtl/hilo_pkg.sv
// ---------------------------------------------------------------------------
// hilo_pkg
// Shared definitions for the HI/LO multiply controller:
//   - HILO_W       : width of the combined {HI,LO} result path
//   - OP_*         : op codes presented on OpCode
//   - state_t      : controller FSM encoding (IDLE=0, WAIT=1, COMMIT=2)
//   - is_mult_class: true for ops that go through the multi-cycle path
// ---------------------------------------------------------------------------
package hilo_pkg;

   localparam int HILO_W = 64;

   localparam logic [2:0] OP_NOP  = 3'd0;
   localparam logic [2:0] OP_MUL  = 3'd1;
   localparam logic [2:0] OP_MADD = 3'd2;
   localparam logic [2:0] OP_MSUB = 3'd3;
   localparam logic [2:0] OP_MTHI = 3'd4;
   localparam logic [2:0] OP_MTLO = 3'd5;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WAIT   = 2'd1,
      ST_COMMIT = 2'd2
   } state_t;

   // MUL/MADD/MSUB occupy the FSM; MTHI/MTLO complete in the accept cycle.
   function automatic logic is_mult_class(input logic [2:0] op);
      return (op == OP_MUL) || (op == OP_MADD) || (op == OP_MSUB);
   endfunction

endpackage

// File: rtl/hilo_accum.sv
// ---------------------------------------------------------------------------
// hilo_accum
// Combinational 64-bit commit datapath for the HI/LO pair.
//   op_i   in  3   latched op (MUL passes, MADD adds, MSUB subtracts)
//   acc_i  in  64  current {HI,LO}
//   prod_i in  64  latched ALU product
//   res_o  out 64  value to be written into {HI,LO}; wraps mod 2^64
// ---------------------------------------------------------------------------
module hilo_accum
   import hilo_pkg::*;
(
   input  logic [2:0]        op_i,
   input  logic [HILO_W-1:0] acc_i,
   input  logic [HILO_W-1:0] prod_i,
   output logic [HILO_W-1:0] res_o
);

   // Select pass/add/sub; unused op codes fall back to a plain pass.
   always_comb begin
      res_o = prod_i;
      case (op_i)
         OP_MUL:  res_o = prod_i;
         OP_MADD: res_o = acc_i + prod_i;
         OP_MSUB: res_o = acc_i - prod_i;
         default: res_o = prod_i;
      endcase
   end

endmodule

// File: rtl/hilo_mul_ctrl.sv
// ---------------------------------------------------------------------------
// hilo_mul_ctrl
// Sequences multiply-class ops through a MUL_LAT-cycle latency model and owns
// the HI/LO register pair. MTHI/MTLO write in the accept cycle; MUL/MADD/MSUB
// latch the ALU product, wait, then commit via hilo_accum.
//
// Parameter:
//   MUL_LAT     cycles from accept to HI/LO commit (1..15)
// Ports:
//   Clk         in   1   rising-edge clock
//   Reset       in   1   synchronous, active-high
//   OpValid     in   1   op request, held by upstream while Stall=1
//   OpCode      in   3   NOP/MUL/MADD/MSUB/MTHI/MTLO (see hilo_pkg)
//   ALUProduct  in   64  product, sampled on accept
//   RsData      in   32  MTHI/MTLO source
//   ReadReq     in   1   MFHI/MFLO in EX
//   Flush       in   1   abort in-flight multi-cycle op
//   Stall       out  1   combinational pipeline hold
//   Busy        out  1   multi-cycle op in flight (registered)
//   Done        out  1   pulse in the COMMIT cycle (registered)
//   Hi, Lo      out  32  HI/LO registers
// Configuration macro HILO_FORWARD_EN: when defined, Hi/Lo show the commit
// value during COMMIT and a ReadReq in COMMIT does not stall.
// ---------------------------------------------------------------------------
module hilo_mul_ctrl
   import hilo_pkg::*;
#(
   parameter int MUL_LAT = 3
)
(
   input  logic              Clk,
   input  logic              Reset,
   input  logic              OpValid,
   input  logic [2:0]        OpCode,
   input  logic [HILO_W-1:0] ALUProduct,
   input  logic [31:0]       RsData,
   input  logic              ReadReq,
   input  logic              Flush,
   output logic              Stall,
   output logic              Busy,
   output logic              Done,
   output logic [31:0]       Hi,
   output logic [31:0]       Lo
);

   localparam logic [3:0] CNT_INIT = 4'(MUL_LAT - 1);
   // A single-cycle latency skips WAIT and commits right after accept.
   localparam state_t FIRST_ST = (MUL_LAT > 1) ? ST_WAIT : ST_COMMIT;

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [HILO_W-1:0] prod_q, prod_d;
   logic [2:0]        op_q, op_d;
   logic [31:0]       hi_q, hi_d;
   logic [31:0]       lo_q, lo_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic              op_req_s;
   logic              accept_s;
   logic              fwd_ok_s;
   logic [HILO_W-1:0] accum_res_s;

   assign op_req_s = OpValid & (OpCode != OP_NOP);
   // Flush outranks accept, and nothing is accepted while an op is in flight.
   assign accept_s = op_req_s & ~busy_q & ~Flush;

   hilo_accum u_accum (
      .op_i   (op_q),
      .acc_i  ({hi_q, lo_q}),
      .prod_i (prod_q),
      .res_o  (accum_res_s)
   );

   // Next-state logic for FSM, latency counter, operand latches and HI/LO.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      prod_d  = prod_q;
      op_d    = op_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               case (OpCode)
                  OP_MTHI: hi_d = RsData;
                  OP_MTLO: lo_d = RsData;
                  OP_MUL, OP_MADD, OP_MSUB: begin
                     prod_d  = ALUProduct;
                     op_d    = OpCode;
                     cnt_d   = CNT_INIT;
                     state_d = FIRST_ST;
                  end
                  default: state_d = ST_IDLE;
               endcase
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (Flush) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d   = cnt_q - 4'd1;
               state_d = (cnt_q == 4'd1) ? ST_COMMIT : ST_WAIT;
            end
         end
         ST_COMMIT: begin
            state_d = ST_IDLE;
            // A flush in the commit cycle discards the result.
            if (!Flush) begin
               {hi_d, lo_d} = accum_res_s;
            end else begin
               {hi_d, lo_d} = {hi_q, lo_q};
            end
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d != ST_IDLE);
      done_d = (state_d == ST_COMMIT);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         prod_q  <= {HILO_W{1'b0}};
         op_q    <= OP_NOP;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         prod_q  <= prod_d;
         op_q    <= op_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

`ifdef HILO_FORWARD_EN
   assign fwd_ok_s = (state_q == ST_COMMIT);

   // During COMMIT the value about to be written is forwarded to readers.
   always_comb begin
      if (fwd_ok_s) begin
         {Hi, Lo} = accum_res_s;
      end else begin
         {Hi, Lo} = {hi_q, lo_q};
      end
   end
`else
   assign fwd_ok_s = 1'b0;
   assign Hi       = hi_q;
   assign Lo       = lo_q;
`endif

   assign Stall = (op_req_s & busy_q) | (ReadReq & busy_q & ~fwd_ok_s);
   assign Busy  = busy_q;
   assign Done  = done_q;

endmodule

// File: tb/tb_hilo_mul_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hilo_mul_ctrl
// Self-checking bench for hilo_mul_ctrl: directed scenarios with literal
// expectations, then randomized traffic. A behavioural model tracks the
// HI/LO pair and the age of the in-flight op; a negedge process compares
// every DUT output against it each cycle.
// ---------------------------------------------------------------------------
module tb_hilo_mul_ctrl;

   localparam int MUL_LAT = 3;
`ifdef HILO_FORWARD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        Reset = 1'b1;
   logic        OpValid = 1'b0;
   logic [2:0]  OpCode = 3'd0;
   logic [63:0] ALUProduct = 64'd0;
   logic [31:0] RsData = 32'd0;
   logic        ReadReq = 1'b0;
   logic        Flush = 1'b0;
   logic        Stall, Busy, Done;
   logic [31:0] Hi, Lo;

   int n_tests = 0;
   int n_fail  = 0;

   hilo_mul_ctrl #(.MUL_LAT(MUL_LAT)) dut (
      .Clk(clk), .Reset(Reset), .OpValid(OpValid), .OpCode(OpCode),
      .ALUProduct(ALUProduct), .RsData(RsData), .ReadReq(ReadReq),
      .Flush(Flush), .Stall(Stall), .Busy(Busy), .Done(Done),
      .Hi(Hi), .Lo(Lo)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   logic [63:0] m_hl = 64'd0;    // architectural {HI,LO}
   bit          m_pend = 1'b0;   // multi-cycle op in flight
   int          m_age = 0;       // cycles since accept (1..MUL_LAT)
   logic [2:0]  m_op = 3'd0;
   logic [63:0] m_prod = 64'd0;
   bit          m_valid = 1'b0;

   function automatic logic [63:0] commit_val(input logic [2:0] op,
                                              input logic [63:0] hl,
                                              input logic [63:0] p);
      if (op == 3'd2) return hl + p;
      if (op == 3'd3) return hl - p;
      return p;
   endfunction

   always @(posedge clk) begin
      if (Reset) begin
         m_hl    <= 64'd0;
         m_pend  <= 1'b0;
         m_age   <= 0;
         m_valid <= 1'b1;
      end else if (m_valid) begin
         if (m_pend) begin
            if (Flush) m_pend <= 1'b0;
            else if (m_age == MUL_LAT) begin
               m_hl   <= commit_val(m_op, m_hl, m_prod);
               m_pend <= 1'b0;
            end else m_age <= m_age + 1;
         end else if (OpValid && OpCode != 3'd0 && !Flush) begin
            if (OpCode == 3'd4) m_hl[63:32] <= RsData;
            else if (OpCode == 3'd5) m_hl[31:0] <= RsData;
            else begin
               m_pend <= 1'b1;
               m_age  <= 1;
               m_op   <= OpCode;
               m_prod <= ALUProduct;
            end
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Compare process: every cycle once the model is in a known state.
   always @(negedge clk) begin
      if (m_valid) begin
         logic        e_done, e_stall;
         logic [63:0] e_hl;
         e_done  = m_pend && (m_age == MUL_LAT);
         e_hl    = (FWD && e_done) ? commit_val(m_op, m_hl, m_prod) : m_hl;
         e_stall = (OpValid && OpCode != 3'd0 && m_pend) ||
                   (ReadReq && m_pend && !(FWD && e_done));
         chk("busy", {63'd0, Busy}, {63'd0, m_pend});
         chk("done", {63'd0, Done}, {63'd0, e_done});
         chk("stall", {63'd0, Stall}, {63'd0, e_stall});
         chk("hilo", {Hi, Lo}, e_hl);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic v, input logic [2:0] op, input logic [63:0] prod,
                         input logic [31:0] rs, input logic rr, input logic fl,
                         input logic rst);
      OpValid = v; OpCode = op; ALUProduct = prod; RsData = rs;
      ReadReq = rr; Flush = fl; Reset = rst;
      #1;
   endtask

   task automatic idle();
      set_in(1'b0, 3'd0, 64'd0, 32'd0, 1'b0, 1'b0, 1'b0);
   endtask

   logic [31:0] save_hi, save_lo;

   initial begin
      // 1. Reset
      set_in(1'b0, 3'd0, 64'd0, 32'd0, 1'b0, 1'b0, 1'b1);
      tick();
      idle();
      chk("rst_hi", {32'd0, Hi}, 64'd0);
      chk("rst_lo", {32'd0, Lo}, 64'd0);
      chk("rst_busy", {63'd0, Busy}, 64'd0);
      chk("rst_done", {63'd0, Done}, 64'd0);
      chk("rst_stall", {63'd0, Stall}, 64'd0);

      // 2. MUL timing and result
      set_in(1'b1, 3'd1, 64'h0000_0002_FFFF_FFFE, 32'd0, 1'b0, 1'b0, 1'b0);
      tick(); idle();
      chk("mul_c1_busy", {63'd0, Busy}, 64'd1);
      chk("mul_c1_done", {63'd0, Done}, 64'd0);
      tick();
      chk("mul_c2_busy", {63'd0, Busy}, 64'd1);
      chk("mul_c2_done", {63'd0, Done}, 64'd0);
      tick();
      chk("mul_c3_busy", {63'd0, Busy}, 64'd1);
      chk("mul_c3_done", {63'd0, Done}, 64'd1);
      tick();
      chk("mul_c4_busy", {63'd0, Busy}, 64'd0);
      chk("mul_hi", {32'd0, Hi}, 64'h2);
      chk("mul_lo", {32'd0, Lo}, 64'hFFFF_FFFE);

      // 3. MADD wrap, then MSUB wrap
      set_in(1'b1, 3'd4, 64'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0); tick();
      set_in(1'b1, 3'd5, 64'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0); tick();
      set_in(1'b1, 3'd2, 64'd1, 32'd0, 1'b0, 1'b0, 1'b0); tick();
      idle();
      repeat (MUL_LAT) tick();
      chk("madd_hi", {32'd0, Hi}, 64'd0);
      chk("madd_lo", {32'd0, Lo}, 64'd0);
      set_in(1'b1, 3'd3, 64'd1, 32'd0, 1'b0, 1'b0, 1'b0); tick();
      idle();
      repeat (MUL_LAT) tick();
      chk("msub_hi", {32'd0, Hi}, 64'hFFFF_FFFF);
      chk("msub_lo", {32'd0, Lo}, 64'hFFFF_FFFF);

      // 4. Read hazard
      set_in(1'b1, 3'd1, 64'h0000_0005_0000_0007, 32'd0, 1'b0, 1'b0, 1'b0); tick();
      set_in(1'b0, 3'd0, 64'd0, 32'd0, 1'b1, 1'b0, 1'b0);
      chk("haz_c1", {63'd0, Stall}, 64'd1);
      tick();
      chk("haz_c2", {63'd0, Stall}, 64'd1);
      tick();
      chk("haz_c3", {63'd0, Stall}, FWD ? 64'd0 : 64'd1);
      tick();
      chk("haz_c4", {63'd0, Stall}, 64'd0);
      chk("haz_lo", {32'd0, Lo}, 64'h7);
      //    Structural hazard: second MUL held from cycle 1
      set_in(1'b1, 3'd1, 64'd3, 32'd0, 1'b0, 1'b0, 1'b0); tick();
      set_in(1'b1, 3'd1, 64'd9, 32'd0, 1'b0, 1'b0, 1'b0);
      for (int i = 1; i <= MUL_LAT; i++) begin
         chk("struct_stall", {63'd0, Stall}, 64'd1);
         tick();
      end
      chk("struct_accept_c4", {63'd0, Stall}, 64'd0);
      chk("struct_first_lo", {32'd0, Lo}, 64'd3);
      tick(); idle();
      chk("struct_busy_c5", {63'd0, Busy}, 64'd1);
      repeat (MUL_LAT) tick();
      chk("struct_second_lo", {32'd0, Lo}, 64'd9);

      // 5. Flush in WAIT
      save_hi = Hi; save_lo = Lo;
      set_in(1'b1, 3'd1, 64'h1111_1111_2222_2222, 32'd0, 1'b0, 1'b0, 1'b0); tick();
      idle(); tick();
      set_in(1'b0, 3'd0, 64'd0, 32'd0, 1'b0, 1'b1, 1'b0); tick();
      idle();
      chk("flush_busy", {63'd0, Busy}, 64'd0);
      chk("flush_done", {63'd0, Done}, 64'd0);
      tick();
      chk("flush_done2", {63'd0, Done}, 64'd0);
      chk("flush_hilo", {Hi, Lo}, {save_hi, save_lo});
      //    Reset mid-op
      set_in(1'b1, 3'd1, 64'h3333_3333_4444_4444, 32'd0, 1'b0, 1'b0, 1'b0); tick();
      idle(); tick();
      set_in(1'b0, 3'd0, 64'd0, 32'd0, 1'b0, 1'b0, 1'b1); tick();
      idle();
      chk("rstmid_hilo", {Hi, Lo}, 64'd0);
      chk("rstmid_busy", {63'd0, Busy}, 64'd0);
      tick();
      chk("rstmid_done", {63'd0, Done}, 64'd0);

      // 6. MTHI/MTLO back-to-back, then MTHI while busy
      set_in(1'b1, 3'd4, 64'd0, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
      chk("mthi_stall", {63'd0, Stall}, 64'd0);
      tick();
      set_in(1'b1, 3'd5, 64'd0, 32'h1234_5678, 1'b0, 1'b0, 1'b0);
      chk("mtlo_stall", {63'd0, Stall}, 64'd0);
      chk("mthi_hi", {32'd0, Hi}, 64'hDEAD_BEEF);
      tick(); idle();
      chk("mtlo_lo", {32'd0, Lo}, 64'h1234_5678);
      chk("mt_busy", {63'd0, Busy}, 64'd0);
      set_in(1'b1, 3'd1, 64'd42, 32'd0, 1'b0, 1'b0, 1'b0); tick();
      set_in(1'b1, 3'd4, 64'd0, 32'hCAFE_F00D, 1'b0, 1'b0, 1'b0);
      for (int i = 1; i <= MUL_LAT; i++) begin
         chk("mtbusy_stall", {63'd0, Stall}, 64'd1);
         tick();
      end
      chk("mtbusy_free", {63'd0, Stall}, 64'd0);
      tick(); idle();
      chk("mtbusy_hi", {32'd0, Hi}, 64'hCAFE_F00D);
      chk("mtbusy_lo", {32'd0, Lo}, 64'd42);

      // Randomized traffic against the model
      for (int n = 0; n < 3000; n++) begin
         set_in($urandom_range(0, 2) != 0, 3'($urandom_range(0, 5)),
                {$urandom, $urandom}, $urandom, 1'($urandom_range(0, 1)),
                $urandom_range(0, 15) == 0, $urandom_range(0, 99) == 0);
         tick();
      end
      idle();
      tick();
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
